// File: rtl/conv_frame_streamer_if.sv
// Frame streamer bus: start/status handshake, synchronous RAM read port and
// the raster pixel stream toward the 3x3 line buffer.
interface conv_frame_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [DATA_WIDTH-1:0] pix_out;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_sof;
  logic                  pix_eol;
  logic                  pix_flush;

  // streamer side
  modport master (
    input  start, mem_rd_data, pix_ready,
    output busy, done, mem_rd_en, mem_rd_addr,
           pix_out, pix_valid, pix_sof, pix_eol, pix_flush
  );

  // RAM / line buffer / controller side
  modport slave (
    output start, mem_rd_data, pix_ready,
    input  busy, done, mem_rd_en, mem_rd_addr,
           pix_out, pix_valid, pix_sof, pix_eol, pix_flush
  );
endinterface

// File: rtl/conv_frame_streamer.sv
// Raster-order frame streamer: prefetches pixels from a 1-cycle-latency RAM,
// streams them with valid/ready plus sof/eol sidebands, then appends
// IMG_WIDTH+1 zero flush beats and pulses done.
module conv_frame_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_frame_streamer_if.master bus
);
  localparam int NPIX       = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_WIDTH = $clog2(NPIX);
  localparam int XW         = $clog2(IMG_WIDTH);
  localparam int YW         = $clog2(IMG_HEIGHT);
  localparam int FW         = $clog2(IMG_WIDTH + 1);

  localparam logic [ADDR_WIDTH:0] RD_END = (ADDR_WIDTH+1)'(NPIX);
  localparam logic [XW-1:0]       X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]       Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0]       F_LAST = FW'(IMG_WIDTH);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH:0]     rd_idx;    // next raster index to read
  logic                    rd_vld;    // RAM data is on mem_rd_data this cycle
  logic [DATA_WIDTH-1:0]   fq [2];    // 2-entry FIFO behind the output register
  logic [1:0]              fq_cnt;
  logic [XW-1:0]           ex;        // position of the pixel at (or next into) the output
  logic [YW-1:0]           ey;
  logic [FW-1:0]           fl_cnt;

  logic                    beat;
  logic                    issue;
  logic                    last_pix;
  logic [2:0]              n;
  logic [DATA_WIDTH-1:0]   it [4];
  logic [XW-1:0]           nx;
  logic [YW-1:0]           ny;

  assign beat     = bus.pix_valid && bus.pix_ready;
  assign last_pix = (ex == X_LAST) && (ey == Y_LAST);

  // Ordered list of pixels held after this edge: unaccepted output, FIFO, RAM return.
  // Slot 0 becomes the output register, slots 1-2 the FIFO. A read is only issued
  // if everything held plus everything in flight still fits in those 3 slots.
  always_comb begin
    n = '0;
    for (int i = 0; i < 4; i++) it[i] = '0;
    if (bus.pix_valid && !beat) begin
      it[n[1:0]] = bus.pix_out;
      n = n + 3'd1;
    end
    if (fq_cnt != 2'd0) begin
      it[n[1:0]] = fq[0];
      n = n + 3'd1;
    end
    if (fq_cnt == 2'd2) begin
      it[n[1:0]] = fq[1];
      n = n + 3'd1;
    end
    if (rd_vld) begin
      it[n[1:0]] = bus.mem_rd_data;
      n = n + 3'd1;
    end
    nx = ex;
    ny = ey;
    if (beat) begin
      if (ex == X_LAST) begin
        nx = '0;
        ny = ey + YW'(1);
      end else begin
        nx = ex + XW'(1);
      end
    end
    issue = (state == STREAM) && (rd_idx < RD_END) &&
            ((n + {2'b00, bus.mem_rd_en}) < 3'd3);
  end

  // Control FSM, prefetch and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      rd_idx          <= '0;
      rd_vld          <= 1'b0;
      fq[0]           <= '0;
      fq[1]           <= '0;
      fq_cnt          <= '0;
      ex              <= '0;
      ey              <= '0;
      fl_cnt          <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.mem_rd_en   <= 1'b0;
      bus.mem_rd_addr <= '0;
      bus.pix_out     <= '0;
      bus.pix_valid   <= 1'b0;
      bus.pix_sof     <= 1'b0;
      bus.pix_eol     <= 1'b0;
      bus.pix_flush   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      rd_vld   <= bus.mem_rd_en;
      case (state)
        IDLE: begin
          bus.mem_rd_en <= 1'b0;
          if (bus.start) begin
            // first read goes out with the state change so data lands at +2
            state           <= STREAM;
            bus.busy        <= 1'b1;
            bus.mem_rd_en   <= 1'b1;
            bus.mem_rd_addr <= '0;
            rd_idx          <= (ADDR_WIDTH+1)'(1);
            fq_cnt          <= '0;
            ex              <= '0;
            ey              <= '0;
          end
        end
        STREAM: begin
          bus.mem_rd_en <= issue;
          if (issue) begin
            bus.mem_rd_addr <= rd_idx[ADDR_WIDTH-1:0];
            rd_idx          <= rd_idx + (ADDR_WIDTH+1)'(1);
          end
          ex <= nx;
          ey <= ny;
          if (beat && last_pix) begin
            state         <= FLUSH;
            fl_cnt        <= '0;
            fq_cnt        <= '0;
            bus.pix_valid <= 1'b1;
            bus.pix_out   <= '0;
            bus.pix_sof   <= 1'b0;
            bus.pix_eol   <= 1'b0;
            bus.pix_flush <= 1'b1;
          end else begin
            bus.pix_valid <= (n != 3'd0);
            bus.pix_out   <= it[0];
            fq[0]         <= it[1];
            fq[1]         <= it[2];
            fq_cnt        <= (n == 3'd0) ? 2'd0 : 2'(n - 3'd1);
            // sidebands only change when a new pixel enters the output register
            if (!bus.pix_valid || beat) begin
              bus.pix_sof <= (n != 3'd0) && (nx == '0) && (ny == '0);
              bus.pix_eol <= (n != 3'd0) && (nx == X_LAST);
            end
          end
        end
        FLUSH: begin
          bus.mem_rd_en <= 1'b0;
          if (beat) begin
            if (fl_cnt == F_LAST) begin
              state         <= DONE;
              bus.pix_valid <= 1'b0;
              bus.pix_flush <= 1'b0;
              bus.done      <= 1'b1;
            end else begin
              fl_cnt <= fl_cnt + FW'(1);
            end
          end
        end
        DONE: begin
          bus.mem_rd_en <= 1'b0;
          state         <= IDLE;
          bus.busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_frame_streamer.sv
// Randomized bench for conv_frame_streamer on a 4x4 frame with a reference
// beat list derived from the RAM contents.
module tb_conv_frame_streamer;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
    logic          flush;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;

  conv_frame_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  conv_frame_streamer #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [N];

  // synchronous RAM, 1-cycle read latency
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_rd_addr];

  int tests = 0;
  int fails = 0;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    addr_q[$];
  int    first_k, last_k, done_k, done_cnt, busy_cnt, stall_viol;
  bit    busy_after, aborted;

  // Reference: every RAM word in raster order, then W+1 zero flush beats.
  function automatic void build_exp();
    exp_q.delete();
    for (int i = 0; i < N + W + 1; i++) begin
      if (i < N) exp_q.push_back({ram[i], i == 0, (i % W) == W - 1, 1'b0});
      else       exp_q.push_back({{DW{1'b0}}, 1'b0, 1'b0, 1'b1});
    end
  endfunction

  function automatic int first_diff();
    int m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic int first_addr_diff();
    if (addr_q.size() != N) return addr_q.size();
    for (int i = 0; i < N; i++) if (addr_q[i] != i) return i;
    return -1;
  endfunction

  task automatic fill_ram(input bit ramp);
    for (int i = 0; i < N; i++) ram[i] = ramp ? DW'(i + 1) : DW'($urandom);
  endtask

  // Pulses start, then drives ready and records beats, reads, stalls and done.
  task automatic run_frame(input int pct, input int restart_at, input int abort_at);
    beat_t cur, held;
    bit    stalled = 0;
    bit    restarted = 0;
    got_q.delete(); addr_q.delete();
    first_k = -1; last_k = -1; done_k = -1;
    done_cnt = 0; busy_cnt = 0; stall_viol = 0; busy_after = 1; aborted = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done_k >= 0) begin
        busy_after = bus.busy;
        break;
      end
      bus.pix_ready = ($urandom_range(0, 99) < pct);
      bus.start = 1'b0;
      if (restart_at > 0 && !restarted && got_q.size() == restart_at) begin
        bus.start = 1'b1;
        restarted = 1;
      end
      cur = {bus.pix_out, bus.pix_sof, bus.pix_eol, bus.pix_flush};
      if (stalled && (cur !== held || !bus.pix_valid)) stall_viol++;
      if (bus.pix_valid && first_k < 0) first_k = k;
      if (bus.busy) busy_cnt++;
      if (bus.mem_rd_en) addr_q.push_back(int'(bus.mem_rd_addr));
      if (bus.done) begin
        done_cnt++;
        done_k = k;
      end
      if (bus.pix_valid && bus.pix_ready) begin
        got_q.push_back(cur);
        last_k = k;
      end
      stalled = bus.pix_valid && !bus.pix_ready;
      held = cur;
      if (abort_at > 0 && got_q.size() == abort_at) begin
        @(posedge clk); #2;
        rst_n = 1'b0;
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.mem_rd_en, bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_flush} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0000000", {bus.busy, bus.done, bus.mem_rd_en, bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_flush});
    end
    tests++;
    if (bus.mem_rd_addr !== '0 || bus.pix_out !== '0) begin
      fails++;
      $display("FAIL reset_data: got addr=%0h pix=%0h want 0 0", bus.mem_rd_addr, bus.pix_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int bad;
    fill_ram(1); build_exp();
    run_frame(100, 0, 0);
    tests++; if (first_k !== 2) begin fails++; $display("FAIL basic_latency: got %0d want 2", first_k); end
    tests++; if (got_q.size() !== N + W + 1) begin fails++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), N + W + 1); end
    bad = first_diff();
    tests++; if (bad >= 0) begin fails++; $display("FAIL basic_beat %0d: got %h want %h", bad, got_q[bad], exp_q[bad]); end
    tests++; if (last_k - first_k !== N + W) begin fails++; $display("FAIL basic_b2b: got span %0d want %0d", last_k - first_k, N + W); end
    tests++; if (done_cnt !== 1 || done_k !== last_k + 1) begin fails++; $display("FAIL basic_done: got cnt=%0d at %0d want 1 at %0d", done_cnt, done_k, last_k + 1); end
    tests++; if (busy_cnt !== done_k + 1 || busy_after !== 1'b0) begin fails++; $display("FAIL basic_busy: got cnt=%0d after=%0b want %0d 0", busy_cnt, busy_after, done_k + 1); end
    bad = first_addr_diff();
    tests++; if (bad >= 0) begin fails++; $display("FAIL basic_reads: got %0d reads, bad at %0d want %0d sequential", addr_q.size(), bad, N); end
  endtask

  task automatic test_stall();
    int bad;
    fill_ram(0); build_exp();
    run_frame(50, 0, 0);
    tests++; if (got_q.size() !== N + W + 1) begin fails++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), N + W + 1); end
    bad = first_diff();
    tests++; if (bad >= 0) begin fails++; $display("FAIL stall_beat %0d: got %h want %h", bad, got_q[bad], exp_q[bad]); end
    tests++; if (stall_viol !== 0) begin fails++; $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_viol); end
    bad = first_addr_diff();
    tests++; if (bad >= 0) begin fails++; $display("FAIL stall_reads: got %0d reads, bad at %0d want %0d sequential", addr_q.size(), bad, N); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_restart_ignored();
    int bad;
    fill_ram(1); build_exp();
    run_frame(100, 7, 0);
    bad = first_diff();
    tests++; if (got_q.size() !== N + W + 1 || bad >= 0) begin fails++; $display("FAIL restart_beats: got %0d beats, bad at %0d want %0d clean", got_q.size(), bad, N + W + 1); end
    tests++; if (done_cnt !== 1 || busy_after !== 1'b0) begin fails++; $display("FAIL restart_done: got cnt=%0d busy_after=%0b want 1 0", done_cnt, busy_after); end
  endtask

  task automatic test_abort();
    int bad;
    fill_ram(1); build_exp();
    run_frame(100, 0, 9);
    #1;
    tests++;
    if (!aborted || done_cnt !== 0 || {bus.busy, bus.done, bus.mem_rd_en, bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_flush} !== 7'b0 ||
        bus.mem_rd_addr !== '0 || bus.pix_out !== '0) begin
      fails++;
      $display("FAIL abort_outputs: got aborted=%0b done=%0d ctrl=%b addr=%0h pix=%0h want 1 0 0 0 0", aborted, done_cnt,
               {bus.busy, bus.done, bus.mem_rd_en, bus.pix_valid, bus.pix_sof, bus.pix_eol, bus.pix_flush}, bus.mem_rd_addr, bus.pix_out);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(100, 0, 0);
    bad = first_diff();
    tests++; if (got_q.size() !== N + W + 1 || bad >= 0) begin fails++; $display("FAIL abort_restream: got %0d beats, bad at %0d want %0d clean", got_q.size(), bad, N + W + 1); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL abort_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    int bad;
    for (int f = 0; f < 3; f++) begin
      fill_ram(0); build_exp();
      run_frame(70 + 10 * f, 0, 0);
      bad = first_diff();
      tests++; if (got_q.size() !== N + W + 1 || bad >= 0) begin fails++; $display("FAIL b2b_frame%0d: got %0d beats, bad at %0d want %0d clean", f, got_q.size(), bad, N + W + 1); end
      tests++; if (done_cnt !== 1 || stall_viol !== 0) begin fails++; $display("FAIL b2b_done%0d: got done=%0d stalls=%0d want 1 0", f, done_cnt, stall_viol); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_restart_ignored();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
